// File: rtl/ltp_multi_if.sv
// Level/mode inputs and pulse outputs of ltp_multi, grouped for connection as one port.
interface ltp_multi_if #(
    parameter int unsigned CH = 4
);
    logic [CH-1:0] i_level;
    logic [1:0]    i_mode;
    logic [CH-1:0] o_pulse;
    logic          o_any;

    modport master (output i_level, output i_mode, input o_pulse, input o_any);
    modport slave  (input i_level, input i_mode, output o_pulse, output o_any);
endinterface

// File: rtl/ltp_multi.sv
// Multi-channel edge-to-pulse converter with per-channel retriggerable pulse stretcher.
// Optional input debounce is enabled by defining LTP_DEBOUNCE_EN.
module ltp_multi #(
    parameter int unsigned CH = 4,
    parameter int unsigned PW = 1,
    parameter int unsigned DB = 4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    ltp_multi_if.slave bus
);
    localparam int unsigned CW = $clog2(PW + 1);
    localparam logic [CW-1:0] Reload = CW'(PW - 1);

    typedef enum logic {StIdle, StPulse} state_e;

    if (CH < 1 || CH > 32 || PW < 1 || PW > 255 || DB < 2 || DB > 255) begin : g_bad_param
        $error("ltp_multi: parameter out of range");
    end

    state_e        state_q [CH];
    state_e        state_d [CH];
    logic [CW-1:0] cnt_q   [CH];
    logic [CW-1:0] cnt_d   [CH];
    logic [CH-1:0] f_q, f_d;
    logic [CH-1:0] ev;
    logic [CH-1:0] pulse_d;
    logic          any_q;

`ifdef LTP_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DB + 1);
    localparam logic [DW-1:0] DbLast = DW'(DB - 1);

    logic [DW-1:0] db_q [CH];
    logic [DW-1:0] db_d [CH];

    // f flips on the DB-th consecutive sample that disagrees with it.
    always_comb begin
        f_d = f_q;
        for (int unsigned i = 0; i < CH; i++) begin
            db_d[i] = '0;
            if (bus.i_level[i] != f_q[i]) begin
                if (db_q[i] == DbLast) begin
                    f_d[i] = bus.i_level[i];
                end else begin
                    db_d[i] = db_q[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int unsigned i = 0; i < CH; i++) begin
                db_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                db_q[i] <= db_d[i];
            end
        end
    end
`else
    assign f_d = bus.i_level;
`endif

    always_comb begin
        case (bus.i_mode)
            2'b00:   ev = f_d & ~f_q;
            2'b01:   ev = ~f_d & f_q;
            2'b10:   ev = f_d ^ f_q;
            default: ev = '0;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (bus.i_mode == 2'b11) begin
                state_d[i] = StIdle;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    StIdle: begin
                        if (ev[i]) begin
                            state_d[i] = StPulse;
                            cnt_d[i]   = Reload;
                        end
                    end
                    StPulse: begin
                        if (ev[i]) begin
                            cnt_d[i] = Reload;
                        end else if (cnt_q[i] == '0) begin
                            state_d[i] = StIdle;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            pulse_d[i] = (state_d[i] == StPulse);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            f_q   <= '0;
            any_q <= 1'b0;
            for (int unsigned i = 0; i < CH; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
        end else begin
            f_q   <= f_d;
            any_q <= |pulse_d;
            for (int unsigned i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            bus.o_pulse[i] = (state_q[i] == StPulse);
        end
    end

    assign bus.o_any = any_q;

endmodule
